gyruss_sndcmd_sched: RTL and testbench
======================================

// Module: gyruss_sndcmd_sched
// PURPOSE
//  Sound-command scheduler between the main-CPU sound request (SNDRQ/SNDNO) and the
//  sound Z80. Queues commands in a small FIFO and presents them one at a time on a
//  latch. Raises the Z80 IRQ per command and holds the IRQ until acknowledged.
//  Does not issue the next command until the current one is read, so bursts of
//  main-CPU requests are not lost. Sits in the CLK14M domain in front of the sound
//  CPU read mux.
// PARAMETERS
//  DEPTH_LOG2  2      FIFO depth = 2**DEPTH_LOG2 entries of 8 bits
//  GAP_CYC     64     CLK14M cycles of holdoff after a command is read, before the next IRQ
//  TMO_CYC     65535  CLK14M cycles in WAIT_RD before the command is abandoned (0 = never)
// PORTS
//  CLK14M    in   1  14.31818 MHz clock; all logic is on its rising edge
//  RESET     in   1  asynchronous, active-high reset
//  SNDRQ     in   1  main-CPU request level, asynchronous; a rising edge queues SNDNO
//  SNDNO     in   8  command code; stable from 3 CLK14M before to 3 after the SNDRQ rise
//  IACK      in   1  1-cycle pulse: Z80 interrupt acknowledge (sync to CLK14M)
//  RDSTB     in   1  1-cycle pulse: Z80 memory read of the command latch (sync)
//  OVFCLR    in   1  1-cycle pulse: clears OVF
//  SNO       out  8  current command latch, feeds the Z80 read mux
//  IRQ       out  1  Z80 maskable interrupt request, level
//  LEVEL     out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2
//  FULL      out  1  LEVEL == 2**DEPTH_LOG2
//  OVF       out  1  sticky flag: a request was dropped because the FIFO was full
//  BUSY      out  1  state != IDLE
// BEHAVIOUR
//  Reset: SNO=0, IRQ=0, LEVEL=0, FULL=0, OVF=0, BUSY=0, state=IDLE, counters=0.
//    All synchronizer flops are cleared.
//  Input capture: SNDRQ passes through 2 flops, then edge detect (q2 & ~q3).
//    On a detected edge, SNDNO is sampled in that same cycle and pushed.
//    Latency from the SNDRQ rise to a LEVEL increment is 3 CLK14M cycles.
//  Push while FULL: the data is dropped, OVF is set to 1, LEVEL does not change.
//  OVFCLR clears OVF. If OVFCLR and a dropped push occur in the same cycle, OVF ends at 1.
//  FIFO: circular buffer with pointers of DEPTH_LOG2 bits that wrap modulo the depth.
//    A push and a pop in the same cycle are both performed and LEVEL is unchanged.
//    When full, a same-cycle pop happens first, so the push is accepted.
//  FSM states:
//    IDLE: if LEVEL != 0, go to LOAD.
//    LOAD (1 cycle): pop the head into SNO, then go to ASSERT.
//    ASSERT: IRQ=1 and SNO is held. On IACK: IRQ goes to 0 on the next cycle and the
//      FSM goes to WAIT_RD. On RDSTB without IACK (polled read): IRQ goes to 0 and the
//      FSM goes to GAP.
//    WAIT_RD: IRQ=0. The timer counts CLK14M cycles. On RDSTB go to GAP. If the timer
//      reaches TMO_CYC (when TMO_CYC != 0), go to GAP without setting any flag.
//    GAP: wait GAP_CYC cycles, then go to IDLE. SNO keeps its last value.
//  SNO changes only in LOAD, so the Z80 sees a value that is stable between
//    commands; a RDSTB in any state returns the current SNO.
//  IACK or RDSTB in IDLE, LOAD or GAP is ignored.
//  Counters: one shared down-counter of 16 bits.
//    It is loaded on entry to WAIT_RD or GAP and saturates at 0.
//  Back-to-back throughput: with depth 4 and GAP_CYC=64, the minimum spacing between
//    IRQ rises is 1 + (IACK latency) + (RDSTB latency) + 64 + 2 cycles.
//  RESET asserted mid-operation: IRQ drops immediately (async) and the FIFO contents
//    are discarded. After release the block starts in IDLE with an empty FIFO.
// TESTING
//  1. One SNDRQ pulse with SNDNO=0x2A -> LEVEL=1 at +3 cycles. IRQ=1 at +5 with
//     SNO=0x2A. IACK, then RDSTB -> IRQ=0, after 64 GAP cycles BUSY=0.
//  2. Five SNDRQ pulses (0x01..0x05) 10 cycles apart with the Z80 not responding ->
//     0x01 is latched. 0x02..0x05 are queued (LEVEL=4, FULL=1). No OVF, because the
//     pop of 0x01 freed space first; a sixth pulse sets OVF=1.
//  3. Drain test 2 with an IACK+RDSTB loop -> SNO takes 0x01..0x05 in order with one
//     IRQ each, then LEVEL=0 and IRQ=0.
//  4. IACK without RDSTB and TMO_CYC=100 -> WAIT_RD is exited after 100 cycles. The
//     next queued command is issued after GAP. OVF is unchanged.
//  5. Push and pop in the same cycle while FULL -> LEVEL stays at 4 and OVF stays 0.
//     Then OVFCLR together with a drop -> OVF stays 1.
//  6. RESET pulse while in ASSERT with LEVEL=3 -> IRQ=0, SNO=0, LEVEL=0 asynchronously.
//     No IRQ appears after release until a new SNDRQ edge.

Source files
------------

// File: rtl/gyruss_sndcmd_sched.sv
// Sound-command scheduler: queues main-CPU sound requests in a small FIFO and hands
// them to the sound Z80 one at a time through a held latch and a level IRQ.
module gyruss_sndcmd_sched #(
  parameter int DEPTH_LOG2 = 2,
  parameter int GAP_CYC    = 64,
  parameter int TMO_CYC    = 65535
) (
  input  logic                CLK14M,
  input  logic                RESET,
  input  logic                SNDRQ,
  input  logic [7:0]          SNDNO,
  input  logic                IACK,
  input  logic                RDSTB,
  input  logic                OVFCLR,
  output logic [7:0]          SNO,
  output logic                IRQ,
  output logic [DEPTH_LOG2:0] LEVEL,
  output logic                FULL,
  output logic                OVF,
  output logic                BUSY
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [15:0]           GAP_LOAD = 16'(GAP_CYC);
  localparam logic [15:0]           TMO_LOAD = 16'(TMO_CYC);
  localparam logic                  TMO_EN   = (TMO_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ASSERT,
    S_WAIT_RD,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            rqSync_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            sno_q, sno_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  pushReq, pushOk, dropReq;
  logic                  popReq, popOk;
  logic                  fullNow, cntDone;
  logic                  loadTmo, loadGap;

  // SNDRQ is asynchronous: two flops of synchronisation, the third gives the edge.
  always_ff @(posedge CLK14M or posedge RESET) begin
    if (RESET) begin
      rqSync_q <= 3'b000;
    end else begin
      rqSync_q <= {rqSync_q[1:0], SNDRQ};
    end
  end

  assign pushReq = rqSync_q[1] & ~rqSync_q[2];
  assign fullNow = (level_q == LVL_FULL);
  assign popOk   = popReq & (level_q != '0);
  assign pushOk  = pushReq & (~fullNow | popOk);
  assign dropReq = pushReq & fullNow & ~popOk;
  assign cntDone = (cnt_q <= 16'd1);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (pushOk) wrPtr_d = wrPtr_q + PTR_ONE;
    if (popOk)  rdPtr_d = rdPtr_q + PTR_ONE;
    case ({pushOk, popOk})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // A drop in the same cycle as OVFCLR must leave the flag set.
  always_comb begin
    sno_d = popOk ? mem_q[rdPtr_q] : sno_q;
    ovf_d = ovf_q;
    if (OVFCLR)  ovf_d = 1'b0;
    if (dropReq) ovf_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (loadTmo) begin
      cnt_d = TMO_LOAD;
    end else if (loadGap) begin
      cnt_d = GAP_LOAD;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Storage is not reset; clearing the pointers discards the contents.
  always_ff @(posedge CLK14M) begin
    if (pushOk) mem_q[wrPtr_q] <= SNDNO;
  end

  always_ff @(posedge CLK14M or posedge RESET) begin
    if (RESET) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      sno_q   <= 8'h00;
      ovf_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      sno_q   <= sno_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK14M or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IACK wins over RDSTB in ASSERT; both select the exit path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (level_q != '0) state_d = S_LOAD;
      S_LOAD:    state_d = S_ASSERT;
      S_ASSERT: begin
        if (IACK)       state_d = S_WAIT_RD;
        else if (RDSTB) state_d = S_GAP;
      end
      S_WAIT_RD: begin
        if (RDSTB)                  state_d = S_GAP;
        else if (TMO_EN && cntDone) state_d = S_GAP;
      end
      S_GAP:     if (cntDone) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // IRQ is decoded from the async-reset state register, so reset drops it at once.
  always_comb begin
    popReq  = (state_q == S_LOAD);
    IRQ     = (state_q == S_ASSERT);
    BUSY    = (state_q != S_IDLE);
    loadTmo = (state_q == S_ASSERT) && (state_d == S_WAIT_RD);
    loadGap = (state_q != S_GAP) && (state_d == S_GAP);
  end

  assign SNO   = sno_q;
  assign LEVEL = level_q;
  assign FULL  = fullNow;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_gyruss_sndcmd_sched.sv
// Self-checking bench for gyruss_sndcmd_sched: directed scenarios plus randomized
// command bursts, checked against a queue-based model of the command flow.
module tb_gyruss_sndcmd_sched;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 4;
  localparam int GAP_CYC    = 64;
  localparam int TMO_CYC    = 100;

  logic       CLK14M = 1'b0;
  logic       RESET;
  logic       SNDRQ;
  logic [7:0] SNDNO;
  logic       IACK;
  logic       RDSTB;
  logic       OVFCLR;
  logic [7:0] SNO;
  logic       IRQ;
  logic [2:0] LEVEL;
  logic       FULL;
  logic       OVF;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq [$];
  logic [7:0] mSno = 8'h00;
  logic       mOvf = 1'b0;

  always #35 CLK14M = ~CLK14M;

  gyruss_sndcmd_sched #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .GAP_CYC   (GAP_CYC),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .CLK14M(CLK14M),
    .RESET (RESET),
    .SNDRQ (SNDRQ),
    .SNDNO (SNDNO),
    .IACK  (IACK),
    .RDSTB (RDSTB),
    .OVFCLR(OVFCLR),
    .SNO   (SNO),
    .IRQ   (IRQ),
    .LEVEL (LEVEL),
    .FULL  (FULL),
    .OVF   (OVF),
    .BUSY  (BUSY)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK14M);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: a request is queued if there is room, otherwise it only sets the overflow flag.
  function automatic void modelPush(input logic [7:0] c);
    if (mq.size() < DEPTH) mq.push_back(c);
    else mOvf = 1'b1;
  endfunction

  function automatic void modelIssue();
    if (mq.size() > 0) mSno = mq.pop_front();
  endfunction

  // One main-CPU request: SNDRQ high for 4 cycles, then 6 idle cycles.
  task automatic applyStimulus(input logic [7:0] code);
    SNDNO = code;
    SNDRQ = 1'b1;
    tick(4);
    SNDRQ = 1'b0;
    tick(6);
  endtask

  // Serve every outstanding command; the DUT must be in ASSERT on entry.
  task automatic drainAll(input bit forceTmo);
    int  mode;
    int  a;
    int  r;
    bit  first;
    bit  done;
    first = 1'b1;
    done  = 1'b0;
    while (!done) begin
      checkOutput("drain_irq_set", 32'(IRQ), 32'd1);
      checkOutput("drain_sno", 32'(SNO), 32'(mSno));
      mode  = (first && forceTmo) ? 2 : int'($urandom_range(0, 1));
      first = 1'b0;
      a = int'($urandom_range(0, 4));
      tick(a);
      checkOutput("assert_hold_irq", 32'(IRQ), 32'd1);
      if (mode == 1) begin
        RDSTB = 1'b1; tick(1); RDSTB = 1'b0;
        checkOutput("poll_irq_clr", 32'(IRQ), 32'd0);
      end else begin
        IACK = 1'b1; tick(1); IACK = 1'b0;
        checkOutput("iack_irq_clr", 32'(IRQ), 32'd0);
        if (mode == 0) begin
          r = int'($urandom_range(0, 4));
          tick(r);
          RDSTB = 1'b1; tick(1); RDSTB = 1'b0;
        end else begin
          tick(TMO_CYC - 1);
          checkOutput("tmo_busy", 32'(BUSY), 32'd1);
          tick(1);
          checkOutput("tmo_ovf", 32'(OVF), 32'(mOvf));
        end
      end
      if (mq.size() > 0) begin
        tick(10);
        IACK = 1'b1; RDSTB = 1'b1; tick(1); IACK = 1'b0; RDSTB = 1'b0;
        tick(GAP_CYC - 10);
        checkOutput("gap_irq_early", 32'(IRQ), 32'd0);
        tick(1);
        checkOutput("gap_irq_rise", 32'(IRQ), 32'd1);
        modelIssue();
        checkOutput("gap_level", 32'(LEVEL), 32'(mq.size()));
      end else begin
        tick(GAP_CYC - 1);
        checkOutput("end_gap_busy", 32'(BUSY), 32'd1);
        tick(1);
        checkOutput("end_busy", 32'(BUSY), 32'd0);
        checkOutput("end_irq", 32'(IRQ), 32'd0);
        checkOutput("end_level", 32'(LEVEL), 32'd0);
        checkOutput("end_sno_held", 32'(SNO), 32'(mSno));
        done = 1'b1;
      end
    end
  endtask

  initial begin : main
    int         n;
    logic [7:0] code;
    logic [7:0] first;

    RESET = 1'b1; SNDRQ = 1'b0; SNDNO = 8'h00;
    IACK = 1'b0; RDSTB = 1'b0; OVFCLR = 1'b0;
    #100;
    checkOutput("rst_sno", 32'(SNO), 32'd0);
    checkOutput("rst_irq", 32'(IRQ), 32'd0);
    checkOutput("rst_level", 32'(LEVEL), 32'd0);
    checkOutput("rst_full", 32'(FULL), 32'd0);
    checkOutput("rst_ovf", 32'(OVF), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK14M);
    RESET = 1'b0;
    tick(2);

    // Single command, full IACK/RDSTB handshake and gap.
    SNDNO = 8'h2A; SNDRQ = 1'b1;
    tick(2);
    checkOutput("t1_level_early", 32'(LEVEL), 32'd0);
    tick(1);
    checkOutput("t1_level", 32'(LEVEL), 32'd1);
    modelPush(8'h2A);
    tick(1);
    checkOutput("t1_irq_early", 32'(IRQ), 32'd0);
    tick(1);
    modelIssue();
    checkOutput("t1_irq", 32'(IRQ), 32'd1);
    checkOutput("t1_sno", 32'(SNO), 32'(mSno));
    SNDRQ = 1'b0;
    IACK = 1'b1; tick(1); IACK = 1'b0;
    checkOutput("t1_irq_ack", 32'(IRQ), 32'd0);
    RDSTB = 1'b1; tick(1); RDSTB = 1'b0;
    tick(GAP_CYC - 1);
    checkOutput("t1_gap_busy", 32'(BUSY), 32'd1);
    tick(1);
    checkOutput("t1_idle", 32'(BUSY), 32'd0);

    // Burst while the Z80 does not respond, then one request too many.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i));
      modelPush(8'(i));
      if (i == 1) modelIssue();
    end
    checkOutput("t2_level", 32'(LEVEL), 32'(mq.size()));
    checkOutput("t2_full", 32'(FULL), 32'd1);
    checkOutput("t2_ovf", 32'(OVF), 32'(mOvf));
    checkOutput("t2_sno", 32'(SNO), 32'(mSno));
    applyStimulus(8'h06);
    modelPush(8'h06);
    checkOutput("t2_ovf_set", 32'(OVF), 32'(mOvf));
    checkOutput("t2_level_drop", 32'(LEVEL), 32'(mq.size()));
    OVFCLR = 1'b1; tick(1); OVFCLR = 1'b0;
    mOvf = 1'b0;
    checkOutput("t2_ovfclr", 32'(OVF), 32'(mOvf));

    // Push lands on the same edge as the pop of the next command while full.
    IACK = 1'b1; tick(1); IACK = 1'b0;
    RDSTB = 1'b1; tick(1); RDSTB = 1'b0;
    tick(GAP_CYC - 1);
    SNDNO = 8'hA5; SNDRQ = 1'b1;
    tick(3);
    modelIssue();
    modelPush(8'hA5);
    checkOutput("t5_level", 32'(LEVEL), 32'(mq.size()));
    checkOutput("t5_ovf", 32'(OVF), 32'(mOvf));
    checkOutput("t5_irq", 32'(IRQ), 32'd1);
    checkOutput("t5_sno", 32'(SNO), 32'(mSno));
    tick(1); SNDRQ = 1'b0; tick(6);

    // OVFCLR on the same edge as a dropped push.
    SNDNO = 8'h5A; SNDRQ = 1'b1;
    tick(2);
    OVFCLR = 1'b1; tick(1); OVFCLR = 1'b0;
    modelPush(8'h5A);
    checkOutput("t5_ovf_wins", 32'(OVF), 32'(mOvf));
    checkOutput("t5_level_drop", 32'(LEVEL), 32'(mq.size()));
    SNDRQ = 1'b0; tick(6);

    // Drain with the first command abandoned through the WAIT_RD timeout.
    drainAll(1'b1);
    checkOutput("t3_ovf_kept", 32'(OVF), 32'(mOvf));
    OVFCLR = 1'b1; tick(1); OVFCLR = 1'b0;
    mOvf = 1'b0;

    // Reset while asserting with three queued commands.
    first = 8'($urandom_range(1, 255));
    applyStimulus(first);
    modelPush(first);
    modelIssue();
    for (int i = 0; i < 3; i++) begin
      code = 8'($urandom_range(0, 255));
      applyStimulus(code);
      modelPush(code);
    end
    checkOutput("t6_level_pre", 32'(LEVEL), 32'd3);
    checkOutput("t6_sno_pre", 32'(SNO), 32'(first));
    checkOutput("t6_irq_pre", 32'(IRQ), 32'd1);
    RESET = 1'b1;
    #2;
    mq.delete();
    mSno = 8'h00;
    mOvf = 1'b0;
    checkOutput("t6_irq_async", 32'(IRQ), 32'd0);
    checkOutput("t6_sno_async", 32'(SNO), 32'd0);
    checkOutput("t6_level_async", 32'(LEVEL), 32'd0);
    #10;
    RESET = 1'b0;
    tick(20);
    checkOutput("t6_irq_after", 32'(IRQ), 32'd0);
    checkOutput("t6_busy_after", 32'(BUSY), 32'd0);
    checkOutput("t6_level_after", 32'(LEVEL), 32'd0);

    // Randomized bursts, possibly overflowing, each fully drained.
    repeat (4) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        code = 8'($urandom_range(0, 255));
        applyStimulus(code);
        modelPush(code);
        if (i == 0) modelIssue();
      end
      checkOutput("rnd_level", 32'(LEVEL), 32'(mq.size()));
      checkOutput("rnd_full", 32'(FULL), 32'(mq.size() == DEPTH));
      checkOutput("rnd_ovf", 32'(OVF), 32'(mOvf));
      drainAll(1'b0);
      OVFCLR = 1'b1; tick(1); OVFCLR = 1'b0;
      mOvf = 1'b0;
      checkOutput("rnd_ovfclr", 32'(OVF), 32'(mOvf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
